// File: rtl/ascii_uart_tx.sv
// ascii_uart_tx
// Buffers ASCII characters from the transform engine in a small FIFO and
// serializes each one as an 8N1 UART frame so a host terminal can print the
// LaTeX expression. A character flagged as end-of-line can optionally be
// followed by CR LF.
//
// Ports:
//   clk         single clock, rising edge
//   rst_n       synchronous active-low reset
//   char_in     ASCII byte to send
//   char_valid  char_in / char_last are valid this cycle
//   char_last   char_in ends a line (CR LF follows when ADD_CRLF=1)
//   char_ready  FIFO can accept a byte (transfer = valid && ready at an edge)
//   tx          registered UART line, idles high
//   busy        frame in flight, FIFO non-empty or CR/LF still to send
module ascii_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4,
  parameter bit ADD_CRLF     = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] char_in,
  input  logic       char_valid,
  input  logic       char_last,
  output logic       char_ready,
  output logic       tx,
  output logic       busy
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  localparam logic [BAUD_W-1:0] BAUD_MAX     = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_STOP_END = BAUD_W'(CLKS_PER_BIT - 2);
  localparam logic [CNT_W-1:0]  DEPTH_CNT    = CNT_W'(FIFO_DEPTH);

  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  logic [8:0]        fifo_mem_q [FIFO_DEPTH];
  logic [8:0]        fifo_mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              alive_q, alive_d;
  state_e            state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              last_q, last_d;
  logic [1:0]        pending_q, pending_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              stop_tail_q, stop_tail_d;

  logic       fifo_full;
  logic       fifo_empty;
  logic       push;
  logic       pop;
  logic [8:0] head;

  always_comb begin
    fifo_full  = (count_q == DEPTH_CNT);
    fifo_empty = (count_q == '0);
    // alive_q keeps char_ready low until the first edge out of reset.
    char_ready = alive_q && !fifo_full;
    push       = char_valid && char_ready;
    head       = fifo_mem_q[rd_ptr_q];

    alive_d     = 1'b1;
    fifo_mem_d  = fifo_mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    state_d     = state_q;
    baud_d      = baud_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    last_d      = last_q;
    pending_d   = pending_q;
    stop_tail_d = 1'b0;
    pop         = 1'b0;

    unique case (state_q)
      IDLE: begin
        baud_d    = '0;
        bit_idx_d = '0;
        // Pending CR/LF bytes go out before any queued character.
        if (pending_q != 2'd0) begin
          shift_d   = (pending_q == 2'd2) ? CHAR_CR : CHAR_LF;
          pending_d = pending_q - 2'd1;
          last_d    = 1'b0;
          state_d   = START;
        end else if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = head[7:0];
          last_d  = ADD_CRLF && head[8];
          state_d = START;
        end
      end
      START: begin
        if (baud_q == BAUD_MAX) begin
          baud_d  = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (baud_q == BAUD_MAX) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_idx_q == 3'd7) begin
            bit_idx_d = '0;
            state_d   = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      STOP: begin
        // Leave one cycle early: the IDLE evaluation cycle supplies the last
        // stop-bit cycle, so back-to-back frames are exactly 10 bits long.
        if (baud_q == BAUD_STOP_END) begin
          baud_d      = '0;
          state_d     = IDLE;
          stop_tail_d = 1'b1;
          if (last_q) begin
            pending_d = 2'd2;
          end
          last_d = 1'b0;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (push) begin
      fifo_mem_d[wr_ptr_q] = {char_last, char_in};
      wr_ptr_d             = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // The line register lags the state register by one cycle.
    unique case (state_q)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_q[0];
      default: tx_d = 1'b1;
    endcase

    // stop_tail_q covers the final stop-bit cycle spent in IDLE.
    busy_d = (state_q != IDLE) || !fifo_empty || (pending_q != 2'd0) || stop_tail_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_q[i] <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      alive_q     <= 1'b0;
      state_q     <= IDLE;
      baud_q      <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      last_q      <= 1'b0;
      pending_q   <= 2'd0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      stop_tail_q <= 1'b0;
    end else begin
      fifo_mem_q  <= fifo_mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      alive_q     <= alive_d;
      state_q     <= state_d;
      baud_q      <= baud_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      last_q      <= last_d;
      pending_q   <= pending_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
      stop_tail_q <= stop_tail_d;
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_ascii_uart_tx.sv
// tb_ascii_uart_tx
// Drives two ascii_uart_tx instances (a: ADD_CRLF=1, b: ADD_CRLF=0, both
// CLKS_PER_BIT=4, FIFO_DEPTH=4) and compares tx, busy and char_ready every
// cycle against a frame-schedule model: each accepted byte gets a start time
// max(accept+2, line free), occupies 10 bit times (30 with CR LF), and the
// line level is read off that schedule with plain arithmetic.
module tb_ascii_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst_n_a, rst_n_b;
  logic [7:0] char_in_a, char_in_b;
  logic       char_valid_a, char_valid_b;
  logic       char_last_a, char_last_b;
  logic       char_ready_a, char_ready_b;
  logic       tx_a, tx_b;
  logic       busy_a, busy_b;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int         inst;
    int         acc;
    int         start;
    int         nfr;
    logic [7:0] data;
  } entry_t;

  entry_t ents[$];
  int     line_free [2];
  bit     alive [2];
  bit     crlf [2];
  bit     last_acc_a, last_acc_b;
  int     last_start;

  always #5 clk = ~clk;

  ascii_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .ADD_CRLF(1'b1)) dut_a (
    .clk        (clk),
    .rst_n      (rst_n_a),
    .char_in    (char_in_a),
    .char_valid (char_valid_a),
    .char_last  (char_last_a),
    .char_ready (char_ready_a),
    .tx         (tx_a),
    .busy       (busy_a)
  );

  ascii_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .ADD_CRLF(1'b0)) dut_b (
    .clk        (clk),
    .rst_n      (rst_n_b),
    .char_in    (char_in_b),
    .char_valid (char_valid_b),
    .char_last  (char_last_b),
    .char_ready (char_ready_b),
    .tx         (tx_b),
    .busy       (busy_b)
  );

  task automatic checkOutput(input string tag, input logic obs, input logic exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s cyc=%0d got=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  // Byte carried by frame f of an entry's chain (data, then CR, then LF).
  function automatic logic [7:0] frameByte(entry_t e, int f);
    if (f == 0) return e.data;
    if (f == 1) return 8'h0D;
    return 8'h0A;
  endfunction

  function automatic logic expTx(int inst, int t);
    int off, k;
    logic [7:0] b;
    foreach (ents[i]) begin
      if (ents[i].inst == inst && t >= ents[i].start && t < ents[i].start + ents[i].nfr * FRAME) begin
        off = t - ents[i].start;
        k   = (off % FRAME) / CPB;
        b   = frameByte(ents[i], off / FRAME);
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return b[k-1];
      end
    end
    return 1'b1;
  endfunction

  function automatic logic expBusy(int inst, int t);
    foreach (ents[i]) begin
      if (ents[i].inst == inst && t >= ents[i].acc + 1 && t < ents[i].start + ents[i].nfr * FRAME)
        return 1'b1;
    end
    return 1'b0;
  endfunction

  // A byte sits in the FIFO from its accept edge until the edge before its
  // frame's line drop.
  function automatic logic expReady(int inst, int t);
    int occ = 0;
    if (!alive[inst]) return 1'b0;
    foreach (ents[i]) begin
      if (ents[i].inst == inst && ents[i].acc <= t && t < ents[i].start - 1) occ++;
    end
    return (occ < DEPTH);
  endfunction

  task automatic modelEdge(input int inst, input logic rst_n, input bit acc,
                           input logic [7:0] d, input logic l);
    entry_t e;
    for (int i = ents.size() - 1; i >= 0; i--) begin
      if (ents[i].inst == inst && (!rst_n || ents[i].start + ents[i].nfr * FRAME < cyc - 1))
        ents.delete(i);
    end
    if (!rst_n) begin
      line_free[inst] = 0;
      alive[inst]     = 1'b0;
    end else begin
      alive[inst] = 1'b1;
      if (acc) begin
        e.inst  = inst;
        e.acc   = cyc;
        e.start = (cyc + 2 > line_free[inst]) ? cyc + 2 : line_free[inst];
        e.nfr   = (crlf[inst] && l) ? 3 : 1;
        e.data  = d;
        ents.push_back(e);
        line_free[inst] = e.start + e.nfr * FRAME;
        last_start      = e.start;
      end
    end
  endtask

  task automatic tick();
    bit acc_a, acc_b;
    acc_a = rst_n_a && char_valid_a && expReady(0, cyc);
    acc_b = rst_n_b && char_valid_b && expReady(1, cyc);
    @(posedge clk);
    cyc++;
    modelEdge(0, rst_n_a, acc_a, char_in_a, char_last_a);
    modelEdge(1, rst_n_b, acc_b, char_in_b, char_last_b);
    last_acc_a = acc_a;
    last_acc_b = acc_b;
    @(negedge clk);
    checkOutput("tx_a", tx_a, expTx(0, cyc));
    checkOutput("busy_a", busy_a, expBusy(0, cyc));
    checkOutput("ready_a", char_ready_a, expReady(0, cyc));
    checkOutput("tx_b", tx_b, expTx(1, cyc));
    checkOutput("busy_b", busy_b, expBusy(1, cyc));
    checkOutput("ready_b", char_ready_b, expReady(1, cyc));
  endtask

  task automatic applyStimulus(input int inst, input logic v, input logic [7:0] d, input logic l);
    if (inst == 0) begin
      char_valid_a = v;
      char_in_a    = d;
      char_last_a  = l;
    end else begin
      char_valid_b = v;
      char_in_b    = d;
      char_last_b  = l;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic sendByte(input int inst, input logic [7:0] d, input logic l);
    int  guard = 0;
    bit  got   = 0;
    applyStimulus(inst, 1'b1, d, l);
    while (!got && guard < 400) begin
      tick();
      got = (inst == 0) ? last_acc_a : last_acc_b;
      guard++;
    end
    if (!got) begin
      failures++;
      checks++;
      $display("[TB] FAIL send_timeout inst=%0d byte=%h got=none expected=accept", inst, d);
    end
    applyStimulus(inst, 1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    logic [7:0] burst [6];
    int idx, guard, target;
    burst = '{8'h46, 8'h28, 8'h73, 8'h29, 8'h3D, 8'h31};
    crlf[0] = 1'b1;
    crlf[1] = 1'b0;

    $display("[TB] reset with char_valid high");
    rst_n_a = 1'b0;
    rst_n_b = 1'b0;
    applyStimulus(0, 1'b1, 8'h55, 1'b0);
    applyStimulus(1, 1'b1, 8'h55, 1'b0);
    idle(5);
    rst_n_a = 1'b1;
    rst_n_b = 1'b1;
    applyStimulus(0, 1'b0, 8'h00, 1'b0);
    applyStimulus(1, 1'b0, 8'h00, 1'b0);
    idle(3);

    $display("[TB] single byte 0x5C");
    sendByte(0, 8'h5C, 1'b0);
    idle(50);

    $display("[TB] 0x73 with CR LF");
    sendByte(0, 8'h73, 1'b1);
    idle(130);

    $display("[TB] burst F(s)=1");
    idx   = 0;
    guard = 0;
    applyStimulus(0, 1'b1, burst[0], 1'b0);
    while (idx < 6 && guard < 400) begin
      tick();
      if (last_acc_a) begin
        idx++;
        if (idx < 6) applyStimulus(0, 1'b1, burst[idx], 1'b0);
      end
      guard++;
    end
    if (idx < 6) begin
      failures++;
      checks++;
      $display("[TB] FAIL burst_timeout got=%0d expected=6 bytes", idx);
    end
    applyStimulus(0, 1'b0, 8'h00, 1'b0);
    idle(6 * FRAME + 20);

    $display("[TB] reset during DATA bit 3");
    sendByte(0, 8'h41, 1'b0);
    target = last_start + 4 * CPB + 1;
    sendByte(0, 8'h42, 1'b0);
    sendByte(0, 8'h43, 1'b0);
    while (cyc < target) tick();
    rst_n_a = 1'b0;
    idle(3);
    rst_n_a = 1'b1;
    idle(60);

    $display("[TB] ADD_CRLF=0 with last");
    sendByte(1, 8'h2B, 1'b1);
    idle(100);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus(0, 1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 3) == 0));
      applyStimulus(1, 1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 3) == 0));
      tick();
    end
    applyStimulus(0, 1'b0, 8'h00, 1'b0);
    applyStimulus(1, 1'b0, 8'h00, 1'b0);
    guard = 0;
    while ((cyc < line_free[0] + 4 || cyc < line_free[1] + 4) && guard < 5000) begin
      tick();
      guard++;
    end
    idle(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
